// File: rtl/poci_pkg.sv
// ============================================================================
// Module      : poci_pkg
// Description : Shared widths and serializer state encoding for poci_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package poci_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } poci_state_t;

endpackage

`default_nettype wire

// File: rtl/poci_shifter.sv
// ============================================================================
// Module      : poci_shifter
// Description : MSB-first byte serializer; reloads back-to-back every 8 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poci_shifter
    import poci_pkg::*;
(
    input  logic              sclk,
    input  logic              rstn,
    input  logic              frame_rstn,
    input  logic [DATA_W-1:0] load_data,
    output logic              poci,
    output logic              byte_done
);

    poci_state_t          state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    shift_reg;
    logic                 arst_n;

    // A frame timeout abandons the current byte exactly like a full reset does.
    assign arst_n = rstn & frame_rstn;

    always_ff @(posedge sclk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            poci      <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            if (state == IDLE || bit_cnt == '0) begin
                state     <= SHIFT;
                shift_reg <= {load_data[DATA_W-2:0], 1'b0};
                poci      <= load_data[DATA_W-1];
                bit_cnt   <= BIT_CNT_W'(1);
                byte_done <= 1'b0;
            end else begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                poci      <= shift_reg[DATA_W-1];
                byte_done <= (bit_cnt == '1);
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/poci_regfile.sv
// ============================================================================
// Module      : poci_regfile
// Description : Configuration register bank with POCI read-back serializer.
//               Optional POCI_WRITE_COUNT_EN makes the top register a
//               read-only count of accepted writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poci_regfile
    import poci_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int BASE_ADDR = 1
) (
    input  logic                       sclk,
    input  logic                       rstn,
    input  logic                       frame_rstn,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic                       poci,
    output logic                       byte_done,
    output logic                       addr_err,
    output logic [DATA_W*NUM_REGS-1:0] regs_flat
);

    localparam int unsigned ADDR_LO = BASE_ADDR;
    localparam int unsigned ADDR_HI = BASE_ADDR + NUM_REGS - 1;
    localparam int unsigned TOP     = NUM_REGS - 1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_in_range;
    logic              rd_in_range;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              wr_accept;
    logic [DATA_W-1:0] load_data;

    assign wr_in_range = (32'(wr_addr) >= ADDR_LO) && (32'(wr_addr) <= ADDR_HI);
    assign rd_in_range = (32'(rd_addr) >= ADDR_LO) && (32'(rd_addr) <= ADDR_HI);
    assign wr_idx      = wr_addr - ADDR_W'(BASE_ADDR);
    assign rd_idx      = rd_addr - ADDR_W'(BASE_ADDR);

`ifdef POCI_WRITE_COUNT_EN
    // Writes aimed at the counter are silently ignored: neither stored nor counted.
    assign wr_accept = wr_en && wr_in_range && (wr_idx != ADDR_W'(TOP));
`else
    assign wr_accept = wr_en && wr_in_range;
`endif

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            addr_err <= 1'b0;
        end else begin
            if (wr_en && !wr_in_range) begin
                addr_err <= 1'b1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_accept && wr_idx == ADDR_W'(i)) begin
                    regs[i] <= wr_data;
                end
            end
`ifdef POCI_WRITE_COUNT_EN
            if (wr_accept) begin
                regs[TOP] <= regs[TOP] + DATA_W'(1);
            end
`endif
        end
    end

    always_comb begin
        load_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_in_range && rd_idx == ADDR_W'(i)) begin
                load_data = regs[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[DATA_W*g +: DATA_W] = regs[g];
    end

    poci_shifter u_shifter (
        .sclk       (sclk),
        .rstn       (rstn),
        .frame_rstn (frame_rstn),
        .load_data  (load_data),
        .poci       (poci),
        .byte_done  (byte_done)
    );

endmodule

`default_nettype wire

// File: doc/poci_regfile.md
# poci_regfile

Configuration register bank and POCI serializer, directly downstream of the PICO deserializer. Accepts decoded byte writes (address + data) on `sclk`, stores them in `NUM_REGS` 8-bit registers that drive the chip's static configuration, and shifts the register selected by the read address back out MSB-first on `poci`. Frame timeout from the sclk-stop detector realigns the output byte boundary.

## Interface
- `NUM_REGS`, 16: number of 8-bit registers, 1..255.
- `BASE_ADDR`, 1: address of register 0. Address 0 is reserved for "pointer not set".

Ports:
- `sclk`  in  1: clock, SPI clock, all state on posedge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `frame_rstn`  in  1: sclk-stop reset, asynchronous, active-low. Clears serializer state only; registers are retained.
- `wr_en`  in  1: one-cycle write strobe.
- `wr_addr`  in  8: write address.
- `wr_data`  in  8: write data.
- `rd_addr`  in  8: address of the register to serialize, sampled at each byte load.
- `poci`  out  1: serial data out, registered.
- `byte_done`  out  1: high during the cycle the last bit (LSB) of a byte is driven.
- `addr_err`  out  1: sticky flag, set by an out-of-range write.
- `regs_flat`  out  8*NUM_REGS: register contents; register i is at bits [8i+7:8i].

## Operation
- Write acceptance: requires `wr_en`=1 and `BASE_ADDR <= wr_addr <= BASE_ADDR+NUM_REGS-1`. The accepted write sets register `wr_addr-BASE_ADDR` to `wr_data`.
- Write to an out-of-range address, including 0: dropped, and `addr_err` is set to 1. `addr_err` is cleared only by `rstn`.
- Read mux: `rd_addr` in range returns the register value. Out of range, including 0, returns 8'h00.
- Serializer FSM, 2 states:
  - IDLE: entered on reset and on `frame_rstn`. `poci`=0, bit_cnt=0. The next posedge loads shift_reg with mux(`rd_addr`), drives bit 7 on `poci`, sets bit_cnt=1 and goes to SHIFT.
  - SHIFT: each posedge drives the next bit and increments bit_cnt.
  - When bit_cnt=7, the LSB is driven and `byte_done`=1. bit_cnt wraps to 0.
  - On the following posedge the FSM reloads from the current `rd_addr` and drives its bit 7, with no idle gap.
- Simultaneous write and load of the same register: the load captures the pre-write value. The new value appears in the next byte.
- `frame_rstn` low mid-byte: the byte is abandoned and the FSM returns to IDLE. Register writes in flight on that edge are unaffected.
- `rstn` low: all registers are set to 8'h00 and all outputs are cleared.

## Timing
- Reset values: `poci`=0, `byte_done`=0, `addr_err`=0, `regs_flat`=0, FSM=IDLE, bit_cnt=0.
- Write latency: 1 sclk. The value appears on `regs_flat` after the posedge that samples `wr_en`.
- `addr_err` latency: set 1 sclk after the offending `wr_en`.
- `poci` bit k of a byte is valid from posedge k+1 until posedge k+2, counting the load edge as edge 1. The controller samples on the following negedge.
- `byte_done` is asserted for exactly 1 cycle in every 8.
- Registers do not wrap on addresses. Arithmetic `wr_addr-BASE_ADDR` is 8-bit unsigned and is evaluated only after the range check.

## Configuration
- `POCI_WRITE_COUNT_EN` defined:
  - The top register (index NUM_REGS-1) becomes read-only.
  - It holds the count of accepted writes, 8-bit, wrapping 255→0.
  - Writes addressed to it are dropped without setting `addr_err`, and are not counted.
- `POCI_WRITE_COUNT_EN` undefined: all NUM_REGS registers are writable and no counter exists.

## Structure
- Package `poci_pkg`:
  - `DATA_W`=8, `ADDR_W`=8.
  - `poci_state_t` enum {IDLE, SHIFT}.
  - `BIT_CNT_W`=3.
- Sub-module `poci_shifter` holds the FSM, bit_cnt, shift_reg, `poci` and `byte_done`. It takes `load_data[7:0]` from the parent read mux.
- `poci_regfile` holds the register array, write decode, `addr_err` and the optional counter.

## Test plan
- Reset, then 16 idle clocks: `poci`=0 on the first edge, then shifts 8'h00 repeatedly. `byte_done` pulses every 8 clocks. `addr_err`=0.
- Write 8'hA5 to addr 1 and 8'h3C to addr 16, with `rd_addr`=1 then 16: `regs_flat[7:0]`=A5 and `regs_flat[127:120]`=3C. `poci` streams 1010_0101 then 0011_1100.
- Write to addr 0 and addr 17: no register changes, `addr_err`=1 and it stays high until `rstn`.
- Write 8'hFF to addr 2 on the same edge as a load with `rd_addr`=2 (old value 8'h00): that byte is 8'h00 and the next byte is 8'hFF.
- `frame_rstn` pulsed after 3 bits of 8'hA5: `poci`=0 immediately. The next byte starts again from bit 7=1, and register contents are unchanged.
- With `POCI_WRITE_COUNT_EN` defined: 5 valid writes plus 1 write to addr 16 make register 15 read 8'h05 with `addr_err`=0. 256 valid writes wrap it to 8'h00.
